// File: rtl/conv_result_serializer.sv
// Serializes 4-channel conv result groups into a tagged word stream.
// Each group {mask, data0..3} is buffered in a FIFO, then emitted one set
// channel per word, ascending, with oLast on the group's highest channel.
// Storage capacity is DEPTH groups in total, counting the group currently
// being emitted; groups arriving while that capacity is used are dropped
// and counted.
//
//   state | meaning
//   IDLE  | no word presented, waiting for a stored group
//   SEND  | oData/oChan/oLast valid, waiting for iReady
module conv_result_serializer #(
    parameter int ACCW  = 32,
    parameter int DEPTH = 16,
    parameter int CNTW  = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [3:0]                iValid4,
    input  logic [ACCW-1:0]           iData0,
    input  logic [ACCW-1:0]           iData1,
    input  logic [ACCW-1:0]           iData2,
    input  logic [ACCW-1:0]           iData3,
    output logic [ACCW-1:0]           oData,
    output logic [1:0]                oChan,
    output logic                      oLast,
    output logic                      oValid,
    input  logic                      iReady,
    output logic [$clog2(DEPTH):0]    oLevel,
    output logic                      oOverflow,
    output logic [CNTW-1:0]           oDropCnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 4 * ACCW + 4;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, SEND} state_t;

    logic [EW-1:0]              mem_q [DEPTH];
    logic [AW-1:0]              wr_ptr_q, rd_ptr_q;
    logic [AW:0]                cnt_q;
    state_t                     state_q;
    logic [3:0]                 rem_q;
    logic [3:0][ACCW-1:0]       grp_q;
    logic [ACCW-1:0]            data_q;
    logic [1:0]                 chan_q;
    logic                       last_q, valid_q, ovf_q;
    logic [CNTW-1:0]            drop_q;

    logic [EW-1:0]              head;
    logic [3:0]                 head_mask;
    logic [3:0][ACCW-1:0]       head_data;
    logic [AW:0]                occ;
    logic                       full, push, drop, accept, pop, load_word;
    logic [3:0]                 src_mask, sel_rest;
    logic [3:0][ACCW-1:0]       src_data;
    logic [1:0]                 sel;

    function automatic logic [1:0] low_idx(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    // Capture/drop decision, pop request and next-word selection.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        head_mask = head[4*ACCW +: 4];
        head_data = head[4*ACCW-1:0];
        occ       = cnt_q + (AW + 1)'(state_q == SEND);
        full      = (occ == FULL_LVL);
        push      = (iValid4 != 4'b0) && !full;
        drop      = (iValid4 != 4'b0) && full;
        accept    = valid_q && iReady;
        pop       = (cnt_q != '0) &&
                    ((state_q == IDLE) || (accept && rem_q == 4'b0));
        load_word = pop || (accept && rem_q != 4'b0);
        src_mask  = pop ? head_mask : rem_q;
        src_data  = pop ? head_data : grp_q;
        sel       = low_idx(src_mask);
        sel_rest  = src_mask & ~(4'b0001 << sel);
    end

    // Group storage array; written on push only.
    always_ff @(posedge iClk) begin
        if (push) mem_q[wr_ptr_q] <= {iValid4, iData3, iData2, iData1, iData0};
    end

    // FIFO pointers, level and drop bookkeeping.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      cnt_q <= cnt_q + (AW + 1)'(1);
            else if (pop && !push) cnt_q <= cnt_q - (AW + 1)'(1);
            if (drop) begin
                ovf_q <= 1'b1;
                if (drop_q != '1) drop_q <= drop_q + CNTW'(1);
            end
        end
    end

    // Output stage FSM with registered word outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            rem_q   <= 4'b0;
            grp_q   <= '0;
            data_q  <= '0;
            chan_q  <= 2'd0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            if (load_word) begin
                if (pop) grp_q <= head_data;
                data_q  <= src_data[sel];
                chan_q  <= sel;
                last_q  <= (sel_rest == 4'b0);
                rem_q   <= sel_rest;
                valid_q <= 1'b1;
                state_q <= SEND;
            end else if (accept) begin
                valid_q <= 1'b0;
                state_q <= IDLE;
            end
        end
    end

    assign oData     = data_q;
    assign oChan     = chan_q;
    assign oLast     = last_q;
    assign oValid    = valid_q;
    assign oLevel    = cnt_q;
    assign oOverflow = ovf_q;
    assign oDropCnt  = drop_q;

endmodule
